// File: rtl/acog_id_mt_pkg.sv
// Opcode field positions, instruction codes and the per-entry control bundle
// shared by the cog decode queue and the execute stage.
package acog_id_mt_pkg;

  localparam int OP_Z    = 25;
  localparam int OP_C    = 24;
  localparam int OP_R    = 23;
  localparam int OP_I    = 22;
  localparam int OP_CCCC = 18;

  localparam logic [5:0] I_RDBYTE = 6'b000000;
  localparam logic [5:0] I_RDWORD = 6'b000001;
  localparam logic [5:0] I_RDLONG = 6'b000010;
  localparam logic [5:0] I_JMPRET = 6'b010111;
  localparam logic [5:0] I_DJNZ   = 6'b111001;
  localparam logic [5:0] I_TJNZ   = 6'b111010;
  localparam logic [5:0] I_TJZ    = 6'b111011;

  typedef struct packed {
    logic execute;
    logic save_c;
    logic save_z;
    logic d_from_alu;
    logic d_from_pc_plus_1;
    logic pc_from_pc_plus_1;
    logic pc_from_s;
    logic d_from_hub;
    logic wback_branch;
  } ctrl_t;

  // CCCC is a truth table indexed by {C,Z}.
  function automatic logic cond(input logic [3:0] cccc, input logic c, input logic z);
    return cccc[{c, z}];
  endfunction

  function automatic ctrl_t decode(input logic [31:0] op, input logic ex);
    ctrl_t k;
    k         = '0;
    k.execute = ex;
    k.save_c  = ex & op[OP_C];
    k.save_z  = ex & op[OP_Z];
    case (op[31:26])
      I_RDBYTE, I_RDWORD, I_RDLONG: begin
        k.pc_from_pc_plus_1 = 1'b1;
        k.d_from_hub        = ex & op[OP_R];
      end
      I_JMPRET: begin
        if (ex) begin
          k.pc_from_s        = 1'b1;
          k.d_from_pc_plus_1 = op[OP_R];
        end else begin
          k.pc_from_pc_plus_1 = 1'b1;
        end
      end
      I_DJNZ, I_TJNZ, I_TJZ: begin
        k.d_from_alu        = ex & op[OP_R];
        k.wback_branch      = ex;
        k.pc_from_pc_plus_1 = ~ex;
      end
      default: begin
        k.d_from_alu        = ex & op[OP_R];
        k.pc_from_pc_plus_1 = 1'b1;
      end
    endcase
    return k;
  endfunction

endpackage

// File: rtl/acog_id_mt_cond_eval.sv
// Combinational CCCC condition evaluation against one thread's C/Z flags.
module acog_cond_eval
  import acog_id_mt_pkg::*;
(
  input  logic [3:0] cccc,
  input  logic       c,
  input  logic       z,
  output logic       execute
);

  assign execute = cond(cccc, c, z);

endmodule

// File: rtl/acog_id_mt.sv
// Multi-thread decode stage: evaluates conditions at enqueue and queues the
// resulting write/PC controls for execute, with flag-hazard stall and flush.
module acog_id_mt
  import acog_id_mt_pkg::*;
#(
  parameter  int THREADS = 1,
  parameter  int DEPTH   = 2,
  localparam int TID_W   = (THREADS > 1) ? $clog2(THREADS) : 1
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [31:0]              in_opcode_i,
  input  logic [TID_W-1:0]         in_tid_i,
  input  logic [THREADS-1:0]       flag_c_i,
  input  logic [THREADS-1:0]       flag_z_i,
  input  logic [THREADS-1:0]       flags_busy_i,
  input  logic                     flush_i,
  input  logic [TID_W-1:0]         flush_tid_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              out_opcode_o,
  output logic [TID_W-1:0]         out_tid_o,
  output logic                     out_execute_o,
  output logic                     save_c_o,
  output logic                     save_z_o,
  output logic                     save_d_from_alu_o,
  output logic                     save_d_from_pc_plus_1_o,
  output logic                     save_pc_from_pc_plus_1_o,
  output logic                     save_pc_from_s_o,
  output logic                     save_d_from_hub_o,
  output logic                     wback_branch_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int TN    = 1 << TID_W;

  logic [31:0]      op_q   [DEPTH];
  logic [TID_W-1:0] tid_q  [DEPTH];
  ctrl_t            ctrl_q [DEPTH];
  logic [DEPTH-1:0] kill_q;
  logic [PTR_W-1:0] rd_ptr, wr_ptr, offs;
  logic [PTR_W:0]   count;

  logic [TN-1:0] c_ext, z_ext, busy_ext;
  logic          in_exec, hazard, head_live, push, pop;
  ctrl_t         in_ctrl, head_ctrl;

  // Widen per-thread vectors so any tid value indexes safely.
  always_comb begin
    c_ext    = '0;
    z_ext    = '0;
    busy_ext = '0;
    c_ext[THREADS-1:0]    = flag_c_i;
    z_ext[THREADS-1:0]    = flag_z_i;
    busy_ext[THREADS-1:0] = flags_busy_i;
  end

  acog_cond_eval u_cond (
    .cccc    (in_opcode_i[OP_CCCC +: 4]),
    .c       (c_ext[in_tid_i]),
    .z       (z_ext[in_tid_i]),
    .execute (in_exec)
  );

  assign in_ctrl = decode(in_opcode_i, in_exec);

  // A live queued flag writer of the same thread blocks its successors.
  always_comb begin
    hazard = busy_ext[in_tid_i];
    offs   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PTR_W'(i) - rd_ptr;
      if (({1'b0, offs} < count) && !kill_q[i] && (tid_q[i] == in_tid_i) &&
          (ctrl_q[i].save_c || ctrl_q[i].save_z))
        hazard = 1'b1;
    end
  end

  assign in_ready_o = rst_n_in && (count < (PTR_W+1)'(DEPTH)) && !hazard;
  assign push       = in_valid_i && in_ready_o && !(flush_i && (flush_tid_i == in_tid_i));
  assign head_live  = (count != '0) && !kill_q[rd_ptr];
  assign pop        = (count != '0) && (kill_q[rd_ptr] || out_ready_i);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      kill_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (flush_i && (tid_q[i] == flush_tid_i)) kill_q[i] <= 1'b1;
      if (push) begin
        kill_q[wr_ptr] <= 1'b0;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      op_q[wr_ptr]   <= in_opcode_i;
      tid_q[wr_ptr]  <= in_tid_i;
      ctrl_q[wr_ptr] <= in_ctrl;
    end
  end

  assign head_ctrl = head_live ? ctrl_q[rd_ptr] : '0;

  assign out_valid_o              = head_live;
  assign out_opcode_o             = head_live ? op_q[rd_ptr] : '0;
  assign out_tid_o                = head_live ? tid_q[rd_ptr] : '0;
  assign out_execute_o            = head_ctrl.execute;
  assign save_c_o                 = head_ctrl.save_c;
  assign save_z_o                 = head_ctrl.save_z;
  assign save_d_from_alu_o        = head_ctrl.d_from_alu;
  assign save_d_from_pc_plus_1_o  = head_ctrl.d_from_pc_plus_1;
  assign save_pc_from_pc_plus_1_o = head_ctrl.pc_from_pc_plus_1;
  assign save_pc_from_s_o         = head_ctrl.pc_from_s;
  assign save_d_from_hub_o        = head_ctrl.d_from_hub;
  assign wback_branch_o           = head_ctrl.wback_branch;
  assign occupancy_o              = count;

endmodule

// File: tb/tb_acog_id_mt.sv
// Bench for acog_id_mt: hand-computed control vectors, directed hazard/flush/
// reset sequences and randomized traffic against a queue-based reference.
module tb_acog_id_mt;

  localparam int THREADS = 2;
  localparam int DEPTH   = 4;
  localparam int TID_W   = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [31:0]      in_opcode;
  logic [TID_W-1:0] in_tid;
  logic [1:0]       flag_c, flag_z, flags_busy;
  logic             flush;
  logic [TID_W-1:0] flush_tid;
  logic             out_valid, out_ready;
  logic [31:0]      out_opcode;
  logic [TID_W-1:0] out_tid;
  logic             out_execute, save_c, save_z, d_alu, d_pc1, pc_pc1, pc_s, d_hub, wback;
  logic [2:0]       occupancy;
  logic [8:0]       dut_ctrl;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [31:0] op;
    int          tid;
    bit          killed;
    bit          fw;
    logic [8:0]  ctrl;
  } ent_t;
  ent_t mq[$];

  typedef struct {
    logic [31:0] op;
    logic        c;
    logic        z;
    logic [8:0]  ctrl;
  } vec_t;
  vec_t tbl[13];

  always #5 clk = ~clk;

  assign dut_ctrl = {out_execute, save_c, save_z, d_alu, d_pc1, pc_pc1, pc_s, d_hub, wback};

  acog_id_mt #(.THREADS(THREADS), .DEPTH(DEPTH)) dut (
    .clk_in                   (clk),
    .rst_n_in                 (rst_n),
    .in_valid_i               (in_valid),
    .in_ready_o               (in_ready),
    .in_opcode_i              (in_opcode),
    .in_tid_i                 (in_tid),
    .flag_c_i                 (flag_c),
    .flag_z_i                 (flag_z),
    .flags_busy_i             (flags_busy),
    .flush_i                  (flush),
    .flush_tid_i              (flush_tid),
    .out_valid_o              (out_valid),
    .out_ready_i              (out_ready),
    .out_opcode_o             (out_opcode),
    .out_tid_o                (out_tid),
    .out_execute_o            (out_execute),
    .save_c_o                 (save_c),
    .save_z_o                 (save_z),
    .save_d_from_alu_o        (d_alu),
    .save_d_from_pc_plus_1_o  (d_pc1),
    .save_pc_from_pc_plus_1_o (pc_pc1),
    .save_pc_from_s_o         (pc_s),
    .save_d_from_hub_o        (d_hub),
    .wback_branch_o           (wback),
    .occupancy_o              (occupancy)
  );

  // Expected control vector {execute,save_c,save_z,d_alu,d_pc1,pc_pc1,pc_s,d_hub,wback}.
  function automatic logic [8:0] ref_ctrl(input logic [31:0] op, input bit c, input bit z);
    int instr = int'(op[31:26]);
    int cccc  = int'(op[21:18]);
    bit ex    = ((cccc >> (2 * int'(c) + int'(z))) & 1) != 0;
    bit r     = op[23];
    bit rd    = instr <= 2;
    bit jr    = instr == 23;
    bit br    = (instr >= 57) && (instr <= 59);
    bit pcs   = jr && ex;
    bit wb    = br && ex;
    bit dalu  = ex && r && !rd && !jr;
    bit dpc1  = jr && ex && r;
    bit dhub  = rd && r && ex;
    bit pc1   = !(pcs || wb);
    return {ex, ex & op[24], ex & op[25], dalu, dpc1, pc1, pcs, dhub, wb};
  endfunction

  function automatic bit ref_hazard(input int t);
    if (flags_busy[t]) return 1'b1;
    foreach (mq[i])
      if (mq[i].tid == t && !mq[i].killed && mq[i].fw) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check_output({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_output({tag, "_occupancy"}, 32'(occupancy), 32'd0);
    check_output({tag, "_ctrl"}, 32'(dut_ctrl), 32'd0);
    check_output({tag, "_opcode"}, out_opcode, 32'd0);
    check_output({tag, "_tid"}, 32'(out_tid), 32'd0);
  endtask

  // One clock: compare all outputs with the model at negedge, then advance it.
  task automatic apply_stimulus();
    bit   exp_ready, exp_valid, do_pop, do_push;
    ent_t e;
    @(negedge clk);
    exp_ready = (mq.size() < DEPTH) && !ref_hazard(int'(in_tid));
    exp_valid = (mq.size() > 0) && !mq[0].killed;
    check_output("in_ready", 32'(in_ready), 32'(exp_ready));
    check_output("out_valid", 32'(out_valid), 32'(exp_valid));
    check_output("occupancy", 32'(occupancy), 32'(mq.size()));
    check_output("ctrl", 32'(dut_ctrl), exp_valid ? 32'(mq[0].ctrl) : 32'd0);
    if (exp_valid) begin
      check_output("out_opcode", out_opcode, mq[0].op);
      check_output("out_tid", 32'(out_tid), 32'(mq[0].tid));
    end
    do_pop  = (mq.size() > 0) && (mq[0].killed || out_ready);
    do_push = in_valid && exp_ready && !(flush && flush_tid == in_tid);
    e.op     = in_opcode;
    e.tid    = int'(in_tid);
    e.killed = 1'b0;
    e.ctrl   = ref_ctrl(in_opcode, flag_c[in_tid], flag_z[in_tid]);
    e.fw     = e.ctrl[7] | e.ctrl[6];
    @(posedge clk);
    #1;
    if (do_pop) void'(mq.pop_front());
    if (flush)
      foreach (mq[i]) if (mq[i].tid == int'(flush_tid)) mq[i].killed = 1'b1;
    if (do_push) mq.push_back(e);
  endtask

  task automatic push_one(input logic [31:0] op, input logic [TID_W-1:0] tid);
    in_valid  = 1'b1;
    in_opcode = op;
    in_tid    = tid;
    apply_stimulus();
    in_valid  = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{32'hA0BC0000, 1'b0, 1'b0, 9'b100101000};
    tbl[1]  = '{32'hA0B00000, 1'b0, 1'b0, 9'b000001000};
    tbl[2]  = '{32'hA0B00000, 1'b1, 1'b0, 9'b100101000};
    tbl[3]  = '{32'h853C0000, 1'b0, 1'b0, 9'b110001000};
    tbl[4]  = '{32'h5CBC0000, 1'b0, 1'b0, 9'b100010100};
    tbl[5]  = '{32'h08BC0000, 1'b0, 1'b0, 9'b100001010};
    tbl[6]  = '{32'hE4BC0000, 1'b0, 1'b0, 9'b100100001};
    tbl[7]  = '{32'hE4800000, 1'b0, 1'b0, 9'b000001000};
    tbl[8]  = '{32'h5C800000, 1'b0, 1'b0, 9'b000001000};
    tbl[9]  = '{32'h003C0000, 1'b0, 1'b0, 9'b100001000};
    tbl[10] = '{32'hA2BC0000, 1'b0, 1'b0, 9'b101101000};
    tbl[11] = '{32'hA0A80000, 1'b0, 1'b1, 9'b100101000};
    tbl[12] = '{32'hA0A80000, 1'b1, 1'b0, 9'b000001000};

    rst_n      = 1'b0;
    in_valid   = 1'b1;
    in_opcode  = 32'hA0BC0000;
    in_tid     = '0;
    flag_c     = '0;
    flag_z     = '0;
    flags_busy = '0;
    flush      = 1'b0;
    flush_tid  = '0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Table: one instruction at a time through an empty queue.
    for (int k = 0; k < 13; k++) begin
      flag_c    = {1'b0, tbl[k].c};
      flag_z    = {1'b0, tbl[k].z};
      out_ready = 1'b0;
      push_one(tbl[k].op, 1'b0);
      out_ready = 1'b1;
      #3;
      check_output($sformatf("tbl%0d_valid", k), 32'(out_valid), 32'd1);
      check_output($sformatf("tbl%0d_ctrl", k), 32'(dut_ctrl), 32'(tbl[k].ctrl));
      apply_stimulus();
    end
    flag_c = '0;
    flag_z = '0;

    // Flag hazard: MOV waits behind CMP wc until it pops.
    out_ready = 1'b0;
    push_one(32'h853C0000, 1'b0);
    in_valid  = 1'b1;
    in_opcode = 32'hA0BC0000;
    #3;
    check_output("hz_blocked", 32'(in_ready), 32'd0);
    apply_stimulus();
    out_ready = 1'b1;
    #3;
    check_output("hz_popcycle", 32'(in_ready), 32'd0);
    check_output("hz_save_c", 32'(save_c), 32'd1);
    apply_stimulus();
    #3;
    check_output("hz_cleared", 32'(in_ready), 32'd1);
    apply_stimulus();
    in_valid = 1'b0;
    apply_stimulus();

    // External busy only stalls its own thread.
    flags_busy = 2'b01;
    in_tid     = 1'b0;
    #3;
    check_output("busy_t0", 32'(in_ready), 32'd0);
    apply_stimulus();
    in_tid = 1'b1;
    #3;
    check_output("busy_t1", 32'(in_ready), 32'd1);
    apply_stimulus();
    flags_busy = '0;

    // Flush tid0 out of a tid0,tid1,tid0 queue.
    out_ready = 1'b0;
    push_one(32'hA0BC2222, 1'b0);
    push_one(32'hA0BC1111, 1'b1);
    push_one(32'hA0BC3333, 1'b0);
    flush     = 1'b1;
    flush_tid = 1'b0;
    apply_stimulus();
    flush     = 1'b0;
    out_ready = 1'b1;
    #3;
    check_output("fl_occ3", 32'(occupancy), 32'd3);
    check_output("fl_valid3", 32'(out_valid), 32'd0);
    apply_stimulus();
    #3;
    check_output("fl_occ2", 32'(occupancy), 32'd2);
    check_output("fl_tid", 32'(out_tid), 32'd1);
    check_output("fl_opcode", out_opcode, 32'hA0BC1111);
    apply_stimulus();
    #3;
    check_output("fl_valid1", 32'(out_valid), 32'd0);
    apply_stimulus();
    #3;
    check_output("fl_occ0", 32'(occupancy), 32'd0);

    // Flush coinciding with a matching head pop and a matching push.
    out_ready = 1'b0;
    push_one(32'hA0BC4444, 1'b1);
    in_valid  = 1'b1;
    in_opcode = 32'hA0BC5555;
    in_tid    = 1'b1;
    flush     = 1'b1;
    flush_tid = 1'b1;
    out_ready = 1'b1;
    #3;
    check_output("flp_ready", 32'(in_ready), 32'd1);
    apply_stimulus();
    in_valid = 1'b0;
    flush    = 1'b0;
    #3;
    check_output("flp_occ", 32'(occupancy), 32'd0);
    apply_stimulus();

    // Fill to DEPTH, then reset asynchronously mid-cycle.
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) push_one(32'hA0BC0000 + k, 1'b0);
    in_valid = 1'b1;
    #3;
    check_output("full_ready", 32'(in_ready), 32'd0);
    check_output("full_occ", 32'(occupancy), DEPTH);
    apply_stimulus();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();

    // Randomized traffic against the reference queue.
    for (int n = 0; n < 600; n++) begin
      logic [5:0] pool [10];
      pool = '{6'd0, 6'd1, 6'd2, 6'd23, 6'd57, 6'd58, 6'd59, 6'd40, 6'd33, 6'd12};
      in_valid   = $urandom_range(0, 3) != 0;
      in_opcode  = $urandom;
      in_opcode[31:26] = pool[$urandom_range(0, 9)];
      in_tid     = TID_W'($urandom_range(0, THREADS - 1));
      flag_c     = 2'($urandom);
      flag_z     = 2'($urandom);
      flags_busy = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      flush      = $urandom_range(0, 15) == 0;
      flush_tid  = TID_W'($urandom_range(0, THREADS - 1));
      out_ready  = $urandom_range(0, 3) != 0;
      apply_stimulus();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/acog_id_mt.md
# acog_id_mt

Multi-thread, queued successor of the cog decode stage: sits between fetch and execute/writeback. Accepts one opcode per cycle with a thread tag, evaluates the CCCC condition against that thread's C/Z flags and registers the per-instruction write/PC controls into a DEPTH-entry queue presented to execute by valid/ready. Adds flag-hazard stalling, per-thread flush and deferred-branch tagging.

## Interface
- THREADS, 1: hardware threads (1..4); TID_W = max(1, clog2(THREADS)) is a derived localparam.
- DEPTH, 2: queue entries (power of 2, 2..8).
- clk_in  in  1  clock.
- rst_n_in  in  1  reset; asynchronous assert, active-low.
- in_valid_i / in_ready_o  in/out  1  fetch handshake.
- in_opcode_i  in  32  opcode: [31:26] instr, [25] Z, [24] C, [23] R, [22] I, [21:18] CCCC.
- in_tid_i  in  TID_W  thread of incoming opcode.
- flag_c_i, flag_z_i  in  THREADS  current flags per thread.
- flags_busy_i  in  THREADS  execute has a flag write in flight for thread.
- flush_i, flush_tid_i  in  1, TID_W  kill all queued/incoming entries of a thread.
- out_valid_o / out_ready_i  out/in  1  execute handshake.
- out_opcode_o, out_tid_o, out_execute_o  out  32, TID_W, 1  head entry.
- save_c_o, save_z_o, save_d_from_alu_o, save_d_from_pc_plus_1_o, save_pc_from_pc_plus_1_o, save_pc_from_s_o, save_d_from_hub_o, wback_branch_o  out  1 each  head controls.
- occupancy_o  out  clog2(DEPTH)+1  entries held (incl. killed).

## Operation
- Condition: execute = CCCC[{C,Z}] of thread in_tid_i (0000 never, 1111 always).
- Controls computed at enqueue, stored per entry:
  - RDBYTE/RDWORD/RDLONG (000000/000001/000010): pc_plus_1=1, d_from_hub=R&execute.
  - JMPRET (010111): executed -> pc_from_s=1, d_from_pc_plus_1=R; else pc_plus_1=1.
  - DJNZ/TJNZ/TJZ (111001/111010/111011): executed -> wback_branch=1, no PC control; else pc_plus_1=1.
  - all others: pc_plus_1=1.
  - d_from_alu = execute&R, except 0 for reads and JMPRET (single D-write source).
  - save_c = execute&C; save_z = execute&Z.
- Hazard for thread t: flags_busy_i[t], or any live entry of tid t with save_c|save_z.
- in_ready_o = rst_n_in & (occupancy<DEPTH) & !hazard(in_tid_i). No push-through when full.
- Flush: every queued entry with tid==flush_tid_i marked killed; same-cycle push of that tid is accepted and discarded. Killed entries are never presented: a killed head pops automatically, one per cycle, out_valid_o=0 that cycle.
- Outputs reflect the live head; all save_*, wback_branch_o, out_execute_o are 0 whenever out_valid_o=0.

## Timing
- Reset: queue empty, occupancy_o=0, out_valid_o=0, all controls/out_opcode_o/out_tid_o/out_execute_o=0, in_ready_o=0 while reset asserted. Reset mid-operation discards all entries immediately.
- Latency: accepted at edge N -> out_valid_o from N+1 (empty queue). Throughput 1/cycle.
- Push and pop same cycle: occupancy unchanged. Pop requires out_valid_o&out_ready_i.
- Flush and pop of a matching head in same cycle: counts as pop (entry leaves once).
- Hazard clears in the cycle after the flag-writing entry pops and flags_busy_i drops.
- Pointers wrap modulo DEPTH.

## Structure
- acog_defs: opcode constants, field positions (OP_Z/C/R/I/CCCC), ST_* unchanged, cond function.
- Sub-module acog_cond_eval: combinational CCCC x {C,Z} -> execute, reused by execute stage.
- Queue storage, kill bits, hazard scan inline.

## Test plan
- THREADS=1, flags C=0 Z=0: push 0xA0BC0000 (MOV wr, always) -> next cycle out_valid=1, d_from_alu=1, pc_plus_1=1, execute=1.
- Push 0xA0B00000 (MOV if_c) with C=0 -> execute=0, d_from_alu=0, pc_plus_1=1; with C=1 -> d_from_alu=1.
- Push 0x853C0000 (CMP wc) then 0xA0BC0000, out_ready=0 -> in_ready=0 on second until first pops; save_c=1 on first.
- Push 0x5CBC0000 (JMPRET), 0x08BC0000 (RDLONG), 0xE4BC0000 (DJNZ) -> pc_from_s=1/d_from_pc_plus_1=1; d_from_hub=1/d_from_alu=0; wback_branch=1 with no PC control.
- THREADS=2, DEPTH=4: queue tid0,tid1,tid0, flush tid0 -> only tid1 presented, occupancy 3->0 in 3 pops.
- Fill to DEPTH with out_ready=0 -> in_ready=0, occupancy=DEPTH; assert rst_n_in=0 -> all outputs 0 asynchronously.
